// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - request/result handshake bundle for the multi-cycle ALU
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] opD;
  logic [1:0]       selType;
  logic [1:0]       selOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cbz;
  logic             cout;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, opA, opB, opD, selType, selOp, out_ready,
    input  in_ready, out_valid, res, cbz, cout, zero, busy
  );

  modport slave (
    input  in_valid, opA, opB, opD, selType, selOp, out_ready,
    output in_ready, out_valid, res, cbz, cout, zero, busy
  );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - parametrised multi-cycle ALU, shift-add multiplier, registered result and flags
module alu_mc #(
  parameter int WIDTH     = 16,
  parameter int MUL_BITS  = 1,
  parameter int SIGNED_LT = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave bus,
  inout  wire     dvdd,
  inout  wire     dgnd
);
  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             cbz_q;
  logic             cout_q;
  logic             zero_q;

  logic [WIDTH:0]   sum;
  logic             lt;
  logic             is_mul;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cout;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] acc_next;

  // Supply pins exist only for the physical netlist.
  wire unused_supply = &{1'b0, dvdd, dgnd};

  always_comb begin
    sum     = {1'b0, bus.opA} + {1'b0, bus.opB};
    if (SIGNED_LT != 0) lt = $signed(bus.opA) < $signed(bus.opB);
    else                lt = bus.opA < bus.opB;
    is_mul  = (bus.selType == 2'b00) && (bus.selOp == 2'b10);
    sc_res  = '0;
    sc_cout = 1'b0;
    case (bus.selType)
      2'b00: begin
        case (bus.selOp)
          2'b10:   sc_res = '0;
          2'b11:   sc_res = (bus.opB >= WIDTH_V) ? '0 : (bus.opA >> bus.opB);
          default: {sc_cout, sc_res} = sum;
        endcase
      end
      2'b01: begin
        case (bus.selOp)
          2'b00:   sc_res = bus.opA & bus.opB;
          2'b01:   sc_res = bus.opA | bus.opB;
          2'b10:   sc_res = ~bus.opA;
          default: sc_res = bus.opA ^ bus.opB;
        endcase
      end
      2'b10: begin
        if (bus.selOp[1]) sc_res = bus.opB;
        else              {sc_cout, sc_res} = sum;
      end
      default: begin
        if (bus.selOp[1]) {sc_cout, sc_res} = sum;
        else              sc_res = {{(WIDTH-1){1'b0}}, lt};
      end
    endcase
    // Multiplicand is pre-shifted each step, so the partial product needs no position shift.
    pp       = mcand * WIDTH'(mplier[MUL_BITS-1:0]);
    acc_next = acc + pp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      res_q       <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cbz_q       <= 1'b0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            cbz_q      <= (bus.opD == '0);
            in_ready_q <= 1'b0;
            if (is_mul) begin
              mcand  <= bus.opA;
              mplier <= bus.opB;
              acc    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= S_MUL;
            end else begin
              res_q       <= sc_res;
              cout_q      <= sc_cout;
              zero_q      <= (sc_res == '0);
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(STEPS - 1)) begin
            res_q       <= acc_next;
            cout_q      <= 1'b0;
            zero_q      <= (acc_next == '0);
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.cbz       = cbz_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - bench for alu_mc: two instances (MUL_BITS=1/unsigned LT, MUL_BITS=4/signed LT)
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] opA = '0, opB = '0, opD = '0;
  logic [1:0]  selType = '0, selOp = '0;
  wire         dvdd, dgnd;
  assign dvdd = 1'b1;
  assign dgnd = 1'b0;

  int total = 0;
  int bad   = 0;

  alu_mc_if #(.WIDTH(16)) b0 ();
  alu_mc_if #(.WIDTH(16)) b1 ();

  assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
  assign b0.opA = opA;            assign b1.opA = opA;
  assign b0.opB = opB;            assign b1.opB = opB;
  assign b0.opD = opD;            assign b1.opD = opD;
  assign b0.selType = selType;    assign b1.selType = selType;
  assign b0.selOp = selOp;        assign b1.selOp = selOp;
  assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;

  alu_mc #(.WIDTH(16), .MUL_BITS(1), .SIGNED_LT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .dvdd(dvdd), .dgnd(dgnd));
  alu_mc #(.WIDTH(16), .MUL_BITS(4), .SIGNED_LT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .dvdd(dvdd), .dgnd(dgnd));

  always #5 clk = ~clk;

  // {in_ready, out_valid, busy, cbz, cout, zero, res}
  wire [21:0] o0 = {b0.in_ready, b0.out_valid, b0.busy, b0.cbz, b0.cout, b0.zero, b0.res};
  wire [21:0] o1 = {b1.in_ready, b1.out_valid, b1.busy, b1.cbz, b1.cout, b1.zero, b1.res};

  function automatic logic [21:0] outs(input int i);
    return (i == 0) ? o0 : o1;
  endfunction

  // Reference: {cout, res} from the operation table; instance 1 compares signed.
  function automatic logic [16:0] model(input int i, input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] st, input logic [1:0] so);
    logic [16:0] s;
    logic [31:0] p;
    logic        lt;
    s  = {1'b0, a} + {1'b0, b};
    p  = 32'(a) * 32'(b);
    lt = (i == 1) ? ($signed(a) < $signed(b)) : (a < b);
    case (st)
      2'b00: case (so)
        2'b10:   return {1'b0, p[15:0]};
        2'b11:   return (b >= 16'd16) ? 17'h0 : {1'b0, a >> b};
        default: return s;
      endcase
      2'b01: case (so)
        2'b00:   return {1'b0, a & b};
        2'b01:   return {1'b0, a | b};
        2'b10:   return {1'b0, ~a};
        default: return {1'b0, a ^ b};
      endcase
      2'b10:   return so[1] ? {1'b0, b} : s;
      default: return so[1] ? s : {16'h0, lt};
    endcase
  endfunction

  logic [15:0] r_res[2];
  logic        r_cout[2], r_cbz[2], r_zero[2];
  int          r_lat[2], r_busy[2];
  bit          r_got[2];

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d,
                        input logic [1:0] st, input logic [1:0] so);
    int cyc;
    logic [21:0] o;
    @(negedge clk);
    opA = a; opB = b; opD = d; selType = st; selOp = so;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin r_got[i] = 0; r_busy[i] = 0; r_lat[i] = 0; end
    cyc = 0;
    while (!(r_got[0] && r_got[1]) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      opA = 16'($urandom); opB = 16'($urandom); opD = 16'($urandom);
      selType = 2'($urandom); selOp = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        o = outs(i);
        if (!r_got[i]) begin
          if (o[19]) r_busy[i]++;
          if (o[20]) begin
            r_got[i]  = 1;
            r_lat[i]  = cyc;
            r_res[i]  = o[15:0];
            r_zero[i] = o[16];
            r_cout[i] = o[17];
            r_cbz[i]  = o[18];
          end
        end
      end
    end
    if (!(r_got[0] && r_got[1])) begin
      total++; bad++;
      $display("FAIL run_op_timeout got0=%0d got1=%0d required both 1", r_got[0], r_got[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (outs(i)[20:0] !== 21'h0) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%h required=0", i, outs(i)[20:0]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (outs(i)[21] !== 1'b1) begin
        bad++;
        $display("FAIL reset_in_ready dut%0d got=%b required=1", i, outs(i)[21]);
      end
    end
  endtask

  task automatic test_add_wrap();
    run_op(16'hFFFF, 16'h0001, 16'h0003, 2'b00, 2'b00);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({r_lat[i], r_res[i], r_cout[i], r_zero[i], r_cbz[i]} !== {32'd1, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL add_wrap dut%0d got lat=%0d res=%h cout=%b zero=%b cbz=%b required lat=1 res=0000 cout=1 zero=1 cbz=0",
                 i, r_lat[i], r_res[i], r_cout[i], r_zero[i], r_cbz[i]);
      end
    end
  endtask

  task automatic test_mul();
    run_op(16'h0123, 16'h0010, 16'h0000, 2'b00, 2'b10);
    total++;
    if ({r_lat[0], r_busy[0], r_res[0], r_cout[0]} !== {32'd17, 32'd16, 16'h1230, 1'b0}) begin
      bad++;
      $display("FAIL mul_bits1 got lat=%0d busy=%0d res=%h cout=%b required lat=17 busy=16 res=1230 cout=0",
               r_lat[0], r_busy[0], r_res[0], r_cout[0]);
    end
    total++;
    if ({r_lat[1], r_busy[1], r_res[1], r_cbz[1]} !== {32'd5, 32'd4, 16'h1230, 1'b1}) begin
      bad++;
      $display("FAIL mul_bits4 got lat=%0d busy=%0d res=%h cbz=%b required lat=5 busy=4 res=1230 cbz=1",
               r_lat[1], r_busy[1], r_res[1], r_cbz[1]);
    end
    run_op(16'hFFFF, 16'hFFFF, 16'h0001, 2'b00, 2'b10);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({r_res[i], r_zero[i]} !== {16'h0001, 1'b0}) begin
        bad++;
        $display("FAIL mul_ffff dut%0d got res=%h zero=%b required res=0001 zero=0", i, r_res[i], r_zero[i]);
      end
    end
  endtask

  task automatic test_shift_cmp();
    run_op(16'h8000, 16'd20, 16'h0001, 2'b00, 2'b11);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({r_res[i], r_zero[i]} !== {16'h0000, 1'b1}) begin
        bad++;
        $display("FAIL shift_over dut%0d got res=%h zero=%b required res=0000 zero=1", i, r_res[i], r_zero[i]);
      end
    end
    run_op(16'h8000, 16'h0001, 16'h0001, 2'b11, 2'b00);
    total++;
    if (r_res[0] !== 16'h0000) begin
      bad++;
      $display("FAIL lt_unsigned got res=%h required 0000", r_res[0]);
    end
    total++;
    if (r_res[1] !== 16'h0001) begin
      bad++;
      $display("FAIL lt_signed got res=%h required 0001", r_res[1]);
    end
  endtask

  task automatic test_cbz_set();
    run_op(16'h5555, 16'h1234, 16'h0000, 2'b10, 2'b10);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({r_res[i], r_cbz[i]} !== {16'h1234, 1'b1}) begin
        bad++;
        $display("FAIL cbz_set0 dut%0d got res=%h cbz=%b required res=1234 cbz=1", i, r_res[i], r_cbz[i]);
      end
    end
    run_op(16'h5555, 16'h1234, 16'h0001, 2'b10, 2'b10);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({r_res[i], r_cbz[i]} !== {16'h1234, 1'b0}) begin
        bad++;
        $display("FAIL cbz_set1 dut%0d got res=%h cbz=%b required res=1234 cbz=0", i, r_res[i], r_cbz[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, d;
    logic [1:0]  st, so;
    logic [16:0] e;
    int          lat;
    for (int n = 0; n < 40; n++) begin
      a  = (n % 7 == 0) ? 16'hFFFF : 16'($urandom);
      b  = (n % 5 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      d  = (n % 3 == 0) ? 16'h0000 : 16'($urandom);
      st = 2'($urandom);
      so = 2'($urandom);
      run_op(a, b, d, st, so);
      for (int i = 0; i < 2; i++) begin
        e   = model(i, a, b, st, so);
        lat = (st == 2'b00 && so == 2'b10) ? ((i == 0) ? 17 : 5) : 1;
        total++;
        if ({r_lat[i], r_cout[i], r_res[i], r_zero[i], r_cbz[i]} !==
            {lat, e[16], e[15:0], (e[15:0] == 16'h0), (d == 16'h0)}) begin
          bad++;
          $display("FAIL random dut%0d op=%b/%b a=%h b=%h d=%h got lat=%0d cout=%b res=%h zero=%b cbz=%b required lat=%0d cout=%b res=%h",
                   i, st, so, a, b, d, r_lat[i], r_cout[i], r_res[i], r_zero[i], r_cbz[i], lat, e[16], e[15:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    opA = 16'h00FF; opB = 16'h0F0F; opD = 16'h0005; selType = 2'b01; selOp = 2'b11;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if ({outs(i)[21:20], outs(i)[15:0]} !== {2'b01, 16'h0FF0}) begin
          bad++;
          $display("FAIL backpressure_hold dut%0d cyc=%0d got rdy/vld=%b res=%h required 01 res=0ff0",
                   i, k, outs(i)[21:20], outs(i)[15:0]);
        end
      end
      opA = 16'($urandom); opB = 16'($urandom); selType = 2'b00; selOp = 2'b00;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({outs(i)[21:20], outs(i)[15:0]} !== {2'b10, 16'h0FF0}) begin
        bad++;
        $display("FAIL backpressure_release dut%0d got rdy/vld=%b res=%h required 10 res=0ff0",
                 i, outs(i)[21:20], outs(i)[15:0]);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if ({o0[20], o1[20]} !== 2'b00) begin
      bad++;
      $display("FAIL backpressure_not_queued got vld=%b required 00", {o0[20], o1[20]});
    end
  endtask

  task automatic test_back_to_back();
    bit          pending;
    logic [15:0] exp_res[2];
    logic [16:0] e;
    pending = 0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (pending) begin
          if ({outs(i)[21:20], outs(i)[15:0]} !== {2'b01, exp_res[i]}) begin
            bad++;
            $display("FAIL b2b_done dut%0d cyc=%0d got rdy/vld=%b res=%h required 01 res=%h",
                     i, k, outs(i)[21:20], outs(i)[15:0], exp_res[i]);
          end
        end else if (outs(i)[21:20] !== 2'b10) begin
          bad++;
          $display("FAIL b2b_idle dut%0d cyc=%0d got rdy/vld=%b required 10", i, k, outs(i)[21:20]);
        end
      end
      opA = 16'($urandom); opB = 16'($urandom); opD = 16'($urandom);
      selType = 2'($urandom); selOp = 2'($urandom);
      if (selType == 2'b00 && selOp == 2'b10) selOp = 2'b11;
      in_valid = 1'b1;
      if (!pending) begin
        for (int i = 0; i < 2; i++) begin
          e = model(i, opA, opB, selType, selOp);
          exp_res[i] = e[15:0];
        end
      end
      pending = !pending;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    @(negedge clk);
    opA = 16'h1357; opB = 16'h2468; opD = 16'h0000; selType = 2'b00; selOp = 2'b10;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (o0[19] !== 1'b1) begin
      bad++;
      $display("FAIL mid_mul_busy got busy=%b required 1", o0[19]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({outs(i)[20:19], outs(i)[15:0]} !== 18'h0) begin
        bad++;
        $display("FAIL mid_mul_reset dut%0d got vld/busy=%b res=%h required 00 res=0000",
                 i, outs(i)[20:19], outs(i)[15:0]);
      end
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({o0[21], o1[21]} !== 2'b11) begin
      bad++;
      $display("FAIL mid_mul_ready got rdy=%b required 11", {o0[21], o1[21]});
    end
    stale = 0;
    repeat (25) begin
      @(negedge clk);
      if (o0[20] || o1[20]) stale++;
    end
    total++;
    if (stale !== 0) begin
      bad++;
      $display("FAIL mid_mul_stale got stale_cycles=%0d required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_mul();
    test_shift_cmp();
    test_cbz_set();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
